// File: rtl/lcd_pkg.sv
// Shared KS0066/HD44780 bus constants, FSM/target enums and DDRAM address helpers.
// Pure declarations: no latency, no flow control.
package lcd_pkg;

    localparam logic [7:0] OPC_CLR   = 8'h01;
    localparam logic [7:0] OPC_HOME  = 8'h02;
    localparam logic [7:0] OPC_ENTRY = 8'h04;
    localparam logic [7:0] OPC_DCTRL = 8'h08;
    localparam logic [7:0] OPC_SHIFT = 8'h10;
    localparam logic [7:0] OPC_FSET  = 8'h20;
    localparam logic [7:0] OPC_CGA   = 8'h40;
    localparam logic [7:0] OPC_DDA   = 8'h80;

    localparam logic [6:0] LINE_A_BASE = 7'h00;
    localparam logic [6:0] LINE_B_BASE = 7'h40;
    localparam logic [6:0] LINE_A_LAST = 7'h27;
    localparam logic [6:0] LINE_B_LAST = 7'h67;
    localparam logic [5:0] LINE_LEN    = 6'd16;
    localparam logic [7:0] CHAR_SPACE  = 8'h20;

    typedef enum logic [1:0] {ST_IDLE, ST_STROBE, ST_COMMIT} state_t;
    typedef enum logic {TGT_DDRAM, TGT_CGRAM} tgt_t;

    // Only the first LINE_LEN cells of each 40-char DDRAM line are on screen.
    function automatic logic ac_visible(input logic [6:0] ac);
        return ac[5:0] < LINE_LEN;
    endfunction

    function automatic logic ac_on_line_b(input logic [6:0] ac);
        return (ac & LINE_B_BASE) != 7'h00;
    endfunction

endpackage

// File: rtl/ks0066_ac_step.sv
// Next DDRAM address counter value for one increment/decrement, with the 0x27/0x40 and 0x67/0x00 line wraps.
// Combinational, zero latency; no flow control.
module ks0066_ac_step
    import lcd_pkg::*;
(
    input  logic [6:0] ac_i,
    input  logic       id_i,
    output logic [6:0] ac_next_o
);

    always_comb begin
        ac_next_o = ac_i;
        if (id_i) begin
            if (ac_i == LINE_A_LAST)      ac_next_o = LINE_B_BASE;
            else if (ac_i == LINE_B_LAST) ac_next_o = LINE_A_BASE;
            else                          ac_next_o = ac_i + 7'd1;
        end else begin
            if (ac_i == LINE_B_BASE)      ac_next_o = LINE_A_LAST;
            else if (ac_i == LINE_A_BASE) ac_next_o = LINE_B_LAST;
            else                          ac_next_o = ac_i - 7'd1;
        end
    end

endmodule

// File: rtl/ks0066_bus_responder.sv
// KS0066 8-bit bus responder: decodes E-strobed transactions into a 2x16 DDRAM image, answers status/data reads.
// Commit on the cycle E is seen low after high, results visible next cycle; writes during busy are dropped with err.
module ks0066_bus_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_CYC = 4,
    parameter int CLR_CYC  = 16
) (
    input  logic         mclk,
    input  logic         rst,
    input  logic         e,
    input  logic         rs,
    input  logic         rw,
    input  logic [7:0]   db_in,
    output logic [7:0]   db_out,
    output logic         db_oe,
    output logic [127:0] line_a,
    output logic [127:0] line_b,
    output logic         disp_on,
    output logic         busy,
    output logic         err
);

    localparam int CMAX = (CLR_CYC > BUSY_CYC) ? CLR_CYC : BUSY_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] BUSY_LD = CW'(BUSY_CYC);
    localparam logic [CW-1:0] CLR_LD  = CW'(CLR_CYC);

    state_t         state_q, state_d;
    logic           cap_rs_q, cap_rw_q;
    logic [7:0]     cap_db_q;
    logic [6:0]     ac_q, ac_d, ac_step;
    logic           id_q, id_d;
    tgt_t           tgt_q, tgt_d;
    logic [5:0]     cga_q, cga_d;
    logic           disp_on_q, disp_on_d;
    logic [CW-1:0]  busy_cnt_q, busy_cnt_d;
    logic           err_q, err_d;
    logic [127:0]   line_a_q, line_a_d, line_b_q, line_b_d;
    logic           commit;
    logic [7:0]     rd_char;

    ks0066_ac_step u_ac_step (
        .ac_i      (ac_q),
        .id_i      (id_q),
        .ac_next_o (ac_step)
    );

    // STROBE doubles as the registered copy of e, so STROBE with e low is the falling edge.
    assign commit = (state_q == ST_STROBE) && !e;
    assign busy   = (busy_cnt_q != '0);

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cap_rs_q   <= 1'b0;
            cap_rw_q   <= 1'b0;
            cap_db_q   <= 8'h00;
            ac_q       <= LINE_A_BASE;
            id_q       <= 1'b1;
            tgt_q      <= TGT_DDRAM;
            cga_q      <= 6'd0;
            disp_on_q  <= 1'b0;
            busy_cnt_q <= '0;
            err_q      <= 1'b0;
            line_a_q   <= {16{CHAR_SPACE}};
            line_b_q   <= {16{CHAR_SPACE}};
        end else begin
            state_q    <= state_d;
            if (e) begin
                cap_rs_q <= rs;
                cap_rw_q <= rw;
                cap_db_q <= db_in;
            end
            ac_q       <= ac_d;
            id_q       <= id_d;
            tgt_q      <= tgt_d;
            cga_q      <= cga_d;
            disp_on_q  <= disp_on_d;
            busy_cnt_q <= busy_cnt_d;
            err_q      <= err_d;
            line_a_q   <= line_a_d;
            line_b_q   <= line_b_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ac_d       = ac_q;
        id_d       = id_q;
        tgt_d      = tgt_q;
        cga_d      = cga_q;
        disp_on_d  = disp_on_q;
        busy_cnt_d = busy ? busy_cnt_q - CW'(1) : '0;
        err_d      = 1'b0;
        line_a_d   = line_a_q;
        line_b_d   = line_b_q;

        case (state_q)
            ST_IDLE:   if (e) state_d = ST_STROBE;
            ST_STROBE: if (!e) state_d = ST_COMMIT;
            default:   state_d = e ? ST_STROBE : ST_IDLE;
        endcase

        if (commit) begin
            if (!cap_rw_q && busy) begin
                err_d = 1'b1;
            end else if (!cap_rw_q && !cap_rs_q) begin
                if ((cap_db_q & OPC_DDA) != 8'h00) begin
                    ac_d       = cap_db_q[6:0];
                    tgt_d      = TGT_DDRAM;
                    busy_cnt_d = BUSY_LD;
                end else if ((cap_db_q & OPC_CGA) != 8'h00) begin
                    cga_d      = cap_db_q[5:0];
                    tgt_d      = TGT_CGRAM;
                    busy_cnt_d = BUSY_LD;
                end else if ((cap_db_q & OPC_FSET) != 8'h00) begin
                    busy_cnt_d = BUSY_LD;
                end else if ((cap_db_q & OPC_SHIFT) != 8'h00) begin
                    err_d      = 1'b1;
                    busy_cnt_d = BUSY_LD;
                end else if ((cap_db_q & OPC_DCTRL) != 8'h00) begin
                    disp_on_d  = cap_db_q[2];
                    busy_cnt_d = BUSY_LD;
                end else if ((cap_db_q & OPC_ENTRY) != 8'h00) begin
                    id_d       = cap_db_q[1];
                    err_d      = cap_db_q[0];
                    busy_cnt_d = BUSY_LD;
                end else if ((cap_db_q & OPC_HOME) != 8'h00) begin
                    ac_d       = LINE_A_BASE;
                    busy_cnt_d = CLR_LD;
                end else if ((cap_db_q & OPC_CLR) != 8'h00) begin
                    line_a_d   = {16{CHAR_SPACE}};
                    line_b_d   = {16{CHAR_SPACE}};
                    ac_d       = LINE_A_BASE;
                    id_d       = 1'b1;
                    busy_cnt_d = CLR_LD;
                end
            end else if (!cap_rw_q) begin
                busy_cnt_d = BUSY_LD;
                if (tgt_q == TGT_DDRAM) begin
                    if (ac_visible(ac_q)) begin
                        if (ac_on_line_b(ac_q)) line_b_d[{ac_q[3:0], 3'b000} +: 8] = cap_db_q;
                        else                    line_a_d[{ac_q[3:0], 3'b000} +: 8] = cap_db_q;
                    end
                    ac_d = ac_step;
                end else begin
                    cga_d = id_q ? cga_q + 6'd1 : cga_q - 6'd1;
                end
            end else if (cap_rs_q) begin
                ac_d = ac_step;
            end
        end
    end

    always_comb begin
        rd_char = CHAR_SPACE;
        if (ac_visible(ac_q)) begin
            rd_char = ac_on_line_b(ac_q) ? line_b_q[{ac_q[3:0], 3'b000} +: 8]
                                         : line_a_q[{ac_q[3:0], 3'b000} +: 8];
        end
    end

    assign db_oe   = e && rw;
    assign db_out  = db_oe ? (rs ? rd_char : {busy, ac_q}) : 8'h00;
    assign line_a  = line_a_q;
    assign line_b  = line_b_q;
    assign disp_on = disp_on_q;
    assign err     = err_q;

endmodule
